// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, mem_system and status signals of the instruction/data memory arbiter.
// Latency: none (wires only).
// Backpressure: requests are level-held; the stall outputs tell each requester to keep holding.
interface mem_arbiter_if;
  // instruction fetch port
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data;
  logic        i_done;
  logic        i_stall;
  // data port
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wrdata;
  logic [15:0] d_data;
  logic        d_done;
  logic        d_stall;
  // shared mem_system port
  logic [15:0] mem_addr;
  logic [15:0] mem_datain;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_dataout;
  logic        mem_done;
  logic        mem_err;
  // sticky error flag
  logic        err;

  // arbiter side
  modport slave (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_wrdata, mem_dataout, mem_done, mem_err,
    output i_data, i_done, i_stall, d_data, d_done, d_stall, mem_addr, mem_datain,
    mem_rd, mem_wr, err
  );

  // requester / mem_system side
  modport master (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_wrdata, mem_dataout, mem_done, mem_err,
    input  i_data, i_done, i_stall, d_data, d_done, d_stall, mem_addr, mem_datain,
    mem_rd, mem_wr, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system between the fetch port and the data port, one transaction at a time.
// Latency: eligible request in IDLE issues next cycle; done/data one cycle after mem_done (min 3 cycles).
// Backpressure: requests are held while stalled; a timeout counter bounds each WAIT and flags err.
// Optional: `define MEM_ARB_ROUND_ROBIN_EN alternates the winner on contention (default: data port wins).
module mem_arbiter #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  // timeout fires when the counter would step onto WAIT_LIMIT
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;      // 1 = data port owns the transaction
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_op_wr;
  logic [7:0]  r_cnt;
  logic [15:0] r_i_data;
  logic [15:0] r_d_data;
  logic        r_i_done;
  logic        r_d_done;
  logic        r_err;

  logic        w_i_elig;
  logic        w_d_elig;
  logic        w_grant;
  logic        w_grant_d;
  logic        w_complete;
  logic        w_timeout;
  logic        w_mem_rd;
  logic        w_mem_wr;
  logic        w_err_set;

  // a port whose done is high this cycle is still holding its old request, so it is not eligible
  assign w_i_elig = bus.i_rd & ~r_i_done;
  assign w_d_elig = (bus.d_rd | bus.d_wr) & ~r_d_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_d;  // 1 = data port owned the previous grant

  assign w_grant_d = w_d_elig & (~w_i_elig | ~r_last_d);

  // remember the previous owner so contention alternates
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last_d <= 1'b0;
    else if (w_grant) r_last_d <= w_grant_d;
  end
`else
  assign w_grant_d = w_d_elig;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_i_elig | w_d_elig) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_mem_rd    = ~r_op_wr;
        w_mem_wr    = r_op_wr;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_done) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LIMIT_M1) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // mem_err, timeout and a simultaneous data rd+wr all latch the sticky error
  assign w_err_set = bus.mem_err | w_timeout | (w_grant & w_grant_d & bus.d_rd & bus.d_wr);

  // latch the granted operation, run the WAIT counter, return data and done pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= 1'b0;
      r_addr   <= 16'h0000;
      r_wdata  <= 16'h0000;
      r_op_wr  <= 1'b0;
      r_cnt    <= 8'h00;
      r_i_data <= 16'h0000;
      r_d_data <= 16'h0000;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      if (w_grant) begin
        r_owner <= w_grant_d;
        r_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
        r_wdata <= w_grant_d ? bus.d_wrdata : 16'h0000;
        r_op_wr <= w_grant_d & bus.d_wr;
      end
      if (r_state == ST_ISSUE)     r_cnt <= 8'h00;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 8'h01;
      if (w_complete | w_timeout) begin
        if (r_owner) r_d_done <= 1'b1;
        else         r_i_done <= 1'b1;
      end
      if (w_complete & ~r_op_wr) begin
        if (r_owner) r_d_data <= bus.mem_dataout;
        else         r_i_data <= bus.mem_dataout;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.mem_addr   = r_addr;
  assign bus.mem_datain = r_wdata;
  assign bus.mem_rd     = w_mem_rd;
  assign bus.mem_wr     = w_mem_wr;
  assign bus.i_data     = r_i_data;
  assign bus.d_data     = r_d_data;
  assign bus.i_done     = r_i_done;
  assign bus.d_done     = r_d_done;
  assign bus.i_stall    = bus.i_rd & ~r_i_done;
  assign bus.d_stall    = (bus.d_rd | bus.d_wr) & ~r_d_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized rounds against a transaction-level schedule model with a queue scoreboard.
// Latency: expected issue/done cycles are computed per round from the arbitration and timing rules.
// Backpressure: requesters hold their request through the done cycle and drop it the cycle after.
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  localparam int INF   = 1 << 30;

  typedef struct { int cyc; logic rd; logic wr; logic [15:0] addr; logic [15:0] wdata; } iss_t;
  typedef struct { int cyc; logic [15:0] data; } done_t;
  typedef struct { int k; logic [15:0] rdata; } plan_t;

  logic clk = 1'b0;
  logic rst;
  mem_arbiter_if arb_if ();

  mem_arbiter #(.WAIT_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(arb_if));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // expectation queues (scoreboard) and memory response plan
  iss_t  exp_iss[$];
  done_t exp_i[$];
  done_t exp_d[$];
  plan_t plan_q[$];

  // reference model state
  logic [15:0] m_idata = 16'h0;
  logic [15:0] m_ddata = 16'h0;
  bit          m_last_d = 1'b0;
  int          err_from = INF;
  int          err_inj_cyc = -1;
  bit          spur_en = 1'b0;
  bit          mon_on = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // mem_system stand-in: answers each issue per plan, injects spurious mem_done when idle
  initial begin
    plan_t p;
    bit    pend = 1'b0;
    int    resp_cyc = 0;
    int    busy_until = -1;
    logic [15:0] resp_data = 16'h0;
    arb_if.mem_done    = 1'b0;
    arb_if.mem_err     = 1'b0;
    arb_if.mem_dataout = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      arb_if.mem_done    = 1'b0;
      arb_if.mem_err     = (cyc == err_inj_cyc);
      arb_if.mem_dataout = 16'($urandom);
      if (rst) begin
        pend       = 1'b0;
        busy_until = -1;
      end else if (pend && cyc == resp_cyc) begin
        arb_if.mem_done    = 1'b1;
        arb_if.mem_dataout = resp_data;
        pend               = 1'b0;
      end else if (spur_en && cyc > busy_until && $urandom_range(0, 5) == 0) begin
        arb_if.mem_done = 1'b1;
      end
      @(negedge clk);
      if (!rst && (arb_if.mem_rd || arb_if.mem_wr) && plan_q.size() > 0) begin
        p          = plan_q.pop_front();
        busy_until = cyc + LIMIT;
        if (p.k > 0) begin
          pend      = 1'b1;
          resp_cyc  = cyc + p.k;
          resp_data = p.rdata;
        end
      end
    end
  end

  // monitor: compares every cycle against the scheduled expectations
  initial begin
    logic [15:0] mon_idata = 16'h0;
    logic [15:0] mon_ddata = 16'h0;
    bit e_iss, e_i, e_d;
    forever begin
      @(negedge clk);
      if (rst || !mon_on) begin
        mon_idata = 16'h0;
        mon_ddata = 16'h0;
      end else begin
        while (exp_iss.size() > 0 && exp_iss[0].cyc < cyc) void'(exp_iss.pop_front());
        while (exp_i.size() > 0 && exp_i[0].cyc < cyc) void'(exp_i.pop_front());
        while (exp_d.size() > 0 && exp_d[0].cyc < cyc) void'(exp_d.pop_front());
        e_iss = exp_iss.size() > 0 && exp_iss[0].cyc == cyc;
        e_i   = exp_i.size() > 0 && exp_i[0].cyc == cyc;
        e_d   = exp_d.size() > 0 && exp_d[0].cyc == cyc;

        chk1("mem_rd", arb_if.mem_rd, e_iss ? exp_iss[0].rd : 1'b0);
        chk1("mem_wr", arb_if.mem_wr, e_iss ? exp_iss[0].wr : 1'b0);
        if (e_iss) begin
          chk16("mem_addr", arb_if.mem_addr, exp_iss[0].addr);
          if (exp_iss[0].wr) chk16("mem_datain", arb_if.mem_datain, exp_iss[0].wdata);
          void'(exp_iss.pop_front());
        end

        chk1("i_done", arb_if.i_done, e_i);
        if (e_i) begin
          mon_idata = exp_i[0].data;
          void'(exp_i.pop_front());
        end
        chk16("i_data", arb_if.i_data, mon_idata);

        chk1("d_done", arb_if.d_done, e_d);
        if (e_d) begin
          mon_ddata = exp_d[0].data;
          void'(exp_d.pop_front());
        end
        chk16("d_data", arb_if.d_data, mon_ddata);

        chk1("i_stall", arb_if.i_stall, arb_if.i_rd & ~e_i);
        chk1("d_stall", arb_if.d_stall, (arb_if.d_rd | arb_if.d_wr) & ~e_d);
        chk1("err", arb_if.err, cyc >= err_from);
      end
    end
  end

  // dop: 0 read, 1 write, 2 read+write conflict; k = mem_done delay after issue, 0 = never
  task automatic run_round(input bit use_i, input bit use_d, input int dop,
                           input int k_i, input int k_d,
                           input logic [15:0] ia, input logic [15:0] da, input logic [15:0] dw,
                           input logic [15:0] ri, input logic [15:0] rdd);
    iss_t  s;
    done_t dn;
    plan_t p;
    int    t, k, eff, last;
    int    drop_i = -1;
    int    drop_d = -1;
    int    nsrv;
    bit    d_first, is_d;
    d_first = use_d;
    if (use_i && use_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      d_first = !m_last_d;
`else
      d_first = 1'b1;
`endif
    end
    nsrv = (use_i && use_d) ? 2 : 1;
    t = cyc;
    for (int n = 0; n < nsrv; n++) begin
      is_d    = (n == 0) ? d_first : !d_first;
      k       = is_d ? k_d : k_i;
      eff     = (k > 0) ? k : LIMIT;
      s.cyc   = t + 1;
      s.wr    = is_d && dop != 0;
      s.rd    = !s.wr;
      s.addr  = is_d ? da : ia;
      s.wdata = dw;
      exp_iss.push_back(s);
      p.k     = k;
      p.rdata = is_d ? rdd : ri;
      plan_q.push_back(p);
      dn.cyc  = s.cyc + eff + 1;
      if (is_d) begin
        if (s.rd && k > 0) m_ddata = rdd;
        dn.data = m_ddata;
        exp_d.push_back(dn);
        drop_d = dn.cyc + 1;
      end else begin
        if (k > 0) m_idata = ri;
        dn.data = m_idata;
        exp_i.push_back(dn);
        drop_i = dn.cyc + 1;
      end
      if (is_d && dop == 2 && s.cyc < err_from) err_from = s.cyc;
      if (k == 0 && dn.cyc < err_from) err_from = dn.cyc;
      m_last_d = is_d;
      t = dn.cyc;
    end
    last = t + 1;
    arb_if.i_rd     = use_i;
    arb_if.i_addr   = ia;
    arb_if.d_rd     = use_d && dop != 1;
    arb_if.d_wr     = use_d && dop != 0;
    arb_if.d_addr   = da;
    arb_if.d_wrdata = dw;
    while (cyc < last) begin
      @(posedge clk);
      #1;
      if (cyc == drop_i) arb_if.i_rd = 1'b0;
      if (cyc == drop_d) begin
        arb_if.d_rd = 1'b0;
        arb_if.d_wr = 1'b0;
      end
      // the first-served port is already latched, so its pins may wander
      if (d_first && (arb_if.d_rd || arb_if.d_wr)) begin
        arb_if.d_addr   = 16'($urandom);
        arb_if.d_wrdata = 16'($urandom);
      end else if (!d_first && arb_if.i_rd) begin
        arb_if.i_addr = 16'($urandom);
      end
    end
  endtask

  // asynchronous reset pulse; outputs must clear at once, before any clock edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk1("rst_mem_rd", arb_if.mem_rd, 1'b0);
    chk1("rst_mem_wr", arb_if.mem_wr, 1'b0);
    chk1("rst_i_done", arb_if.i_done, 1'b0);
    chk1("rst_d_done", arb_if.d_done, 1'b0);
    chk1("rst_err", arb_if.err, 1'b0);
    chk16("rst_i_data", arb_if.i_data, 16'h0);
    chk16("rst_d_data", arb_if.d_data, 16'h0);
    chk16("rst_mem_addr", arb_if.mem_addr, 16'h0);
    exp_iss.delete();
    exp_i.delete();
    exp_d.delete();
    plan_q.delete();
    err_from    = INF;
    m_idata     = 16'h0;
    m_ddata     = 16'h0;
    m_last_d    = 1'b0;
    arb_if.i_rd = 1'b0;
    arb_if.d_rd = 1'b0;
    arb_if.d_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic random_rounds(input int n, input bit allow_err);
    int sel, dop, ki, kd;
    for (int r = 0; r < n; r++) begin
      sel = $urandom_range(0, 2);
      dop = $urandom_range(0, 1);
      if (allow_err && $urandom_range(0, 7) == 0) dop = 2;
      ki = $urandom_range(1, LIMIT);
      kd = $urandom_range(1, LIMIT);
      if (allow_err && $urandom_range(0, 5) == 0) ki = 0;
      if (allow_err && $urandom_range(0, 5) == 0) kd = 0;
      run_round(sel != 1, sel != 0, dop, ki, kd, 16'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int R;
    iss_t s;
    plan_t p;
    rst             = 1'b0;
    arb_if.i_rd     = 1'b0;
    arb_if.i_addr   = 16'h0;
    arb_if.d_rd     = 1'b0;
    arb_if.d_wr     = 1'b0;
    arb_if.d_addr   = 16'h0;
    arb_if.d_wrdata = 16'h0;
    @(posedge clk);
    #1;
    do_reset();
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    // single fetch, mem_done two cycles after issue
    run_round(1, 0, 0, 2, 1, 16'h0010, 16'h0, 16'h0, 16'hBEEF, 16'h0);
    @(posedge clk); #1;
    // data write: d_data must stay unchanged
    run_round(0, 1, 1, 1, 3, 16'h0, 16'h0200, 16'h1234, 16'h0, 16'hDEAD);
    @(posedge clk); #1;
    // contention, both reads
    run_round(1, 1, 0, 1, 2, 16'h0100, 16'h0300, 16'h0, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    // d_rd and d_wr together: treated as write, sets err
    run_round(0, 1, 2, 1, 1, 16'h0, 16'h0044, 16'h5A5A, 16'h0, 16'h7777);
    @(posedge clk); #1;
    do_reset();
    @(posedge clk); #1;

    // timeout on the fetch port, then a data read still gets serviced
    run_round(1, 0, 0, 0, 1, 16'h0020, 16'h0, 16'h0, 16'hABCD, 16'h0);
    @(posedge clk); #1;
    run_round(0, 1, 0, 1, 1, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h4242);
    @(posedge clk); #1;

    // reset in the middle of WAIT (err is set from the timeout above)
    R = cyc;
    arb_if.i_rd   = 1'b1;
    arb_if.i_addr = 16'h0ABC;
    s.cyc = R + 1; s.rd = 1'b1; s.wr = 1'b0; s.addr = 16'h0ABC; s.wdata = 16'h0;
    exp_iss.push_back(s);
    p.k = 0; p.rdata = 16'h0;
    plan_q.push_back(p);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    @(posedge clk); #1;
    run_round(1, 0, 0, 1, 1, 16'h0ABD, 16'h0, 16'h0, 16'h9999, 16'h0);
    @(posedge clk); #1;

    // random traffic with spurious idle mem_done, no error sources
    spur_en = 1'b1;
    random_rounds(30, 1'b0);
    // random traffic including timeouts and rd+wr conflicts
    random_rounds(20, 1'b1);
    spur_en = 1'b0;

    // mem_err alone sets the sticky flag
    do_reset();
    @(posedge clk); #1;
    err_inj_cyc = cyc + 1;
    err_from    = cyc + 2;
    run_round(0, 1, 0, 2, 2, 16'h0, 16'h0600, 16'h0, 16'h0, 16'h6060);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog @cyc %0d: got no finish, want finish", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
